exc_irq_ctrl: RTL and testbench

Multi-channel interrupt and exception controller for the MIPS core. It replaces the single `IRQ`/`ker` pair feeding the decoder with a stateful unit that:
- latches, masks and prioritises `NUM_IRQ` interrupt lines;
- tracks user/kernel mode as registered state;
- captures EPC and cause, and issues the PC redirect;
- handles return-from-exception.

It sits beside the control decoder. It drives the decoder's `Interrupt` override and the PC-select exception path.

---
 rtl/exc_irq_ctrl.sv | 122 ++++++++++++
 tb/tb_exc_irq_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/exc_irq_ctrl.sv
// exc_irq_ctrl: latches, masks and prioritises interrupt lines, tracks user/kernel mode,
// captures EPC/cause and issues the PC redirect for interrupts and illegal-opcode exceptions.
`default_nettype none

module exc_irq_ctrl #(
  parameter int                    NUM_IRQ    = 4,
  parameter logic [NUM_IRQ-1:0]    EDGE_MASK  = 4'b0001,
  parameter int                    PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]   IRQ_VECTOR = 32'h80000004,
  parameter logic [PC_WIDTH-1:0]   EXC_VECTOR = 32'h80000008
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                mask_we,
  input  logic [NUM_IRQ-1:0]  mask_wdata,
  input  logic [NUM_IRQ-1:0]  pend_clr,
  input  logic                instr_valid,
  input  logic [PC_WIDTH-1:0] cur_pc,
  input  logic                exc_req,
  input  logic                eret,
  output logic                ker,
  output logic                take,
  output logic                take_is_irq,
  output logic [PC_WIDTH-1:0] vector_pc,
  output logic [PC_WIDTH-1:0] epc,
  output logic [7:0]          cause,
  output logic [NUM_IRQ-1:0]  pending,
  output logic                dbl_fault
);

  typedef enum logic [0:0] {
    USER   = 1'b0,
    KERNEL = 1'b1
  } state_e;

  state_e               state_q;
  logic [NUM_IRQ-1:0]   irq_q;
  logic [NUM_IRQ-1:0]   pend_q;
  logic [NUM_IRQ-1:0]   pend_d;
  logic [NUM_IRQ-1:0]   mask_q;
  logic [PC_WIDTH-1:0]  epc_q;
  logic [7:0]           cause_q;
  logic                 dbl_q;

  logic [NUM_IRQ-1:0]   rise;
  logic [NUM_IRQ-1:0]   active;
  logic [NUM_IRQ-1:0]   svc_clr;
  logic [2:0]           idx;
  logic                 irq_take;
  logic                 exc_take_user;
  logic                 exc_take_ker;

  assign rise    = irq_in & ~irq_q & EDGE_MASK;
  assign pending = pend_q | (irq_in & ~EDGE_MASK);
  assign active  = pending & mask_q;

  // Lowest set index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    idx = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) idx = 3'(i);
    end
  end

  assign irq_take      = (state_q == USER) && instr_valid && (|active);
  assign exc_take_user = (state_q == USER) && instr_valid && !(|active) && exc_req;
  assign exc_take_ker  = (state_q == KERNEL) && instr_valid && exc_req;

  assign take        = irq_take | exc_take_user | exc_take_ker;
  assign take_is_irq = irq_take;
  assign vector_pc   = irq_take ? IRQ_VECTOR : (take ? EXC_VECTOR : '0);

  assign svc_clr = irq_take ? ((NUM_IRQ'(1) << idx) & EDGE_MASK) : '0;
  // A fresh edge in the same cycle as a clear keeps the pending set.
  assign pend_d  = (pend_q & ~pend_clr & ~svc_clr) | rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= USER;
      irq_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      dbl_q   <= 1'b0;
    end else begin
      irq_q  <= irq_in;
      pend_q <= pend_d;
      if (mask_we) mask_q <= mask_wdata;
      case (state_q)
        USER: begin
          if (irq_take) begin
            state_q <= KERNEL;
            epc_q   <= cur_pc;
            cause_q <= {5'b0, idx};
          end else if (exc_take_user) begin
            state_q <= KERNEL;
            epc_q   <= cur_pc;
            cause_q <= 8'h80;
          end
        end
        KERNEL: begin
          if (exc_take_ker) begin
            dbl_q <= 1'b1;
          end else if (instr_valid && eret) begin
            state_q <= USER;
          end
        end
        default: state_q <= USER;
      endcase
    end
  end

  assign ker       = (state_q == KERNEL);
  assign epc       = epc_q;
  assign cause     = cause_q;
  assign dbl_fault = dbl_q;

endmodule

`default_nettype wire

// File: tb/tb_exc_irq_ctrl.sv
// Directed self-checking bench for exc_irq_ctrl; inputs change after the falling edge.
`default_nettype none

module tb_exc_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic [3:0]  pend_clr;
  logic        instr_valid;
  logic [31:0] cur_pc;
  logic        exc_req;
  logic        eret;
  logic        ker;
  logic        take;
  logic        take_is_irq;
  logic [31:0] vector_pc;
  logic [31:0] epc;
  logic [7:0]  cause;
  logic [3:0]  pending;
  logic        dbl_fault;

  int errors = 0;
  int checks = 0;

  exc_irq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .pend_clr    (pend_clr),
    .instr_valid (instr_valid),
    .cur_pc      (cur_pc),
    .exc_req     (exc_req),
    .eret        (eret),
    .ker         (ker),
    .take        (take),
    .take_is_irq (take_is_irq),
    .vector_pc   (vector_pc),
    .epc         (epc),
    .cause       (cause),
    .pending     (pending),
    .dbl_fault   (dbl_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: through the rising edge to the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b0; irq_in = '0; mask_we = 0; mask_wdata = '0; pend_clr = '0;
    instr_valid = 0; cur_pc = '0; exc_req = 0; eret = 0;
    @(negedge clk); settle();
    check("rst_ker", 32'(ker), 0);
    check("rst_epc", epc, 0);
    check("rst_cause", 32'(cause), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_dbl", 32'(dbl_fault), 0);
    check("rst_take", 32'(take), 0);
    check("rst_vec", vector_pc, 0);

    @(negedge clk); reset = 1'b1;
    // eret in USER is an ordinary jr
    eret = 1; instr_valid = 1; tick(); eret = 0; instr_valid = 0; settle();
    check("eret_user_ker", 32'(ker), 0);

    mask_we = 1; mask_wdata = 4'b1111; tick(); mask_we = 0;

    // Edge on line 0
    irq_in = 4'b0001; instr_valid = 1; cur_pc = 32'h00400010; settle();
    check("edge_same_cycle_take", 32'(take), 0);
    tick(); irq_in = '0; settle();
    check("edge_take", 32'(take), 1);
    check("edge_is_irq", 32'(take_is_irq), 1);
    check("edge_vec", vector_pc, 32'h80000004);
    tick(); settle();
    check("edge_ker", 32'(ker), 1);
    check("edge_epc", epc, 32'h00400010);
    check("edge_cause", 32'(cause), 32'h00);
    check("edge_pend_cleared", 32'(pending), 0);
    check("ker_no_take", 32'(take), 0);
    eret = 1; tick(); eret = 0; settle();
    check("eret_ker", 32'(ker), 0);

    // Two level lines, masked to 1010
    instr_valid = 0; mask_we = 1; mask_wdata = 4'b1010; tick(); mask_we = 0;
    irq_in = 4'b1010; instr_valid = 1; cur_pc = 32'h00400014; settle();
    check("lvl_take", 32'(take), 1);
    check("lvl_is_irq", 32'(take_is_irq), 1);
    tick(); settle();
    check("lvl_cause", 32'(cause), 32'h01);
    check("lvl_pending", 32'(pending), 32'b1010);
    irq_in = '0; eret = 1; tick(); eret = 0;

    // Exception with no active interrupt
    instr_valid = 0; mask_we = 1; mask_wdata = 4'b1111; tick(); mask_we = 0;
    exc_req = 1; instr_valid = 1; cur_pc = 32'h00400020; settle();
    check("exc_take", 32'(take), 1);
    check("exc_is_irq", 32'(take_is_irq), 0);
    check("exc_vec", vector_pc, 32'h80000008);
    tick(); settle();
    check("exc_cause", 32'(cause), 32'h80);
    check("exc_epc", epc, 32'h00400020);
    check("exc_ker", 32'(ker), 1);
    check("exc_no_dbl", 32'(dbl_fault), 0);
    exc_req = 0; eret = 1; tick(); eret = 0;

    // Interrupt beats exception
    instr_valid = 0; irq_in = 4'b0001; tick(); irq_in = '0;
    exc_req = 1; instr_valid = 1; cur_pc = 32'h00400030; settle();
    check("prio_is_irq", 32'(take_is_irq), 1);
    check("prio_vec", vector_pc, 32'h80000004);
    tick(); exc_req = 0; settle();
    check("prio_cause", 32'(cause), 32'h00);
    check("prio_epc", epc, 32'h00400030);

    // Edge in KERNEL accumulates, taken right after eret
    irq_in = 4'b0001; tick(); irq_in = '0; settle();
    check("kern_pend", 32'(pending), 32'b0001);
    check("kern_no_take", 32'(take), 0);
    eret = 1; settle();
    check("kern_eret_no_take", 32'(take), 0);
    tick(); eret = 0; cur_pc = 32'h00400040; settle();
    check("post_eret_ker", 32'(ker), 0);
    check("post_eret_take", 32'(take), 1);
    tick(); settle();
    check("post_eret_epc", epc, 32'h00400040);

    // Double fault in KERNEL
    exc_req = 1; settle();
    check("dbl_take", 32'(take), 1);
    check("dbl_vec", vector_pc, 32'h80000008);
    tick(); exc_req = 0; settle();
    check("dbl_set", 32'(dbl_fault), 1);
    check("dbl_epc_kept", epc, 32'h00400040);
    check("dbl_cause_kept", 32'(cause), 32'h00);
    check("dbl_ker", 32'(ker), 1);
    irq_in = 4'b0001; tick(); irq_in = '0; settle();
    check("dbl_sticky", 32'(dbl_fault), 1);
    check("pre_rst_pend", 32'(pending), 32'b0001);

    // Asynchronous reset mid-ISR
    #1 reset = 1'b0; #1;
    check("arst_ker", 32'(ker), 0);
    check("arst_epc", epc, 0);
    check("arst_dbl", 32'(dbl_fault), 0);
    check("arst_pend", 32'(pending), 0);
    check("arst_cause", 32'(cause), 0);
    @(negedge clk); reset = 1'b1; instr_valid = 0;

    // Clear vs set on the edge pending
    mask_we = 1; mask_wdata = 4'b0000; tick(); mask_we = 0;
    irq_in = 4'b0001; tick(); irq_in = '0; tick();
    irq_in = 4'b0001; pend_clr = 4'b0001; tick(); irq_in = '0; pend_clr = '0; settle();
    check("clr_set_wins", 32'(pending), 32'b0001);
    pend_clr = 4'b0001; tick(); pend_clr = '0; settle();
    check("clr_only", 32'(pending), 0);

    // Mask zero blocks takes; new mask only counts from the next edge
    irq_in = 4'b0001; tick(); irq_in = 4'b0100; instr_valid = 1; settle();
    check("mask0_no_take", 32'(take), 0);
    check("mask0_pending", 32'(pending), 32'b0101);
    mask_we = 1; mask_wdata = 4'b1111; settle();
    check("mask_same_cycle", 32'(take), 0);
    tick(); mask_we = 0; settle();
    check("mask_next_take", 32'(take), 1);
    check("mask_next_irq", 32'(take_is_irq), 1);
    tick(); irq_in = '0; settle();
    check("mask_next_cause", 32'(cause), 32'h00);
    check("mask_next_pend", 32'(pending), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
